// File: rtl/vmem_pkg.sv
// Shared types, default parameters and helpers for the vector data memory controller.
package vmem_pkg;

   localparam int unsigned LANES_D      = 6;
   localparam int unsigned LANE_W_D     = 24;
   localparam int unsigned STORE_W_D    = 12;
   localparam int unsigned ADDR_W_D     = 20;
   localparam int unsigned MEM_ADDR_W_D = 19;
   localparam int unsigned IO_SIZE_D    = 76;
   localparam int unsigned MEM_LAT_D    = 1;

   // Working width of sign_extend; callers narrow the result to LANE_W.
   localparam int unsigned SEXT_W = 64;

   typedef enum logic [2:0] {
      IDLE,
      IO,
      ISSUE,
      DRAIN,
      RESP
   } vmem_state_e;

   // Replicate bit from_w-1 of x into every bit above it.
   function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] x,
                                                     input int unsigned       from_w);
      logic [SEXT_W-1:0] r;
      logic              s;
      s = x[6'(from_w - 1)];
      for (int unsigned i = 0; i < SEXT_W; i++) begin
         r[i] = (i < from_w) ? x[i] : s;
      end
      return r;
   endfunction

endpackage

// File: rtl/vector_data_memory_if.sv
// Core-side request/response bus of the vector data memory controller.
interface vector_data_memory_if
   import vmem_pkg::*;
#(
   parameter int unsigned LANES      = LANES_D,
   parameter int unsigned LANE_W     = LANE_W_D,
   parameter int unsigned ADDR_W     = ADDR_W_D,
   parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_D
);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_W-1:0]       req_addr;
   logic [MEM_ADDR_W-1:0]   req_stride;
   logic [LANES*LANE_W-1:0] req_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [LANES*LANE_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_stride, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_stride, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/vmem_addr_gen.sv
// Lane counter and running main-memory address for one serialised vector access.
// The step input is the registered stride when VMEM_STRIDE_EN is defined, else 1.
module vmem_addr_gen
   import vmem_pkg::*;
#(
   parameter  int unsigned LANES      = LANES_D,
   parameter  int unsigned MEM_ADDR_W = MEM_ADDR_W_D,
   localparam int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  advance,
   input  logic [MEM_ADDR_W-1:0] start_addr,
   input  logic [MEM_ADDR_W-1:0] step,
   output logic [MEM_ADDR_W-1:0] addr,
   output logic [LANE_IDX_W-1:0] lane,
   output logic                  last_lane
);

   // Load the base offset on start, then step one lane per advance; wrap is silent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         lane      <= '0;
         last_lane <= 1'b0;
      end else if (start) begin
         addr      <= start_addr;
         lane      <= '0;
         last_lane <= (LANES == 1);
      end else if (advance) begin
         addr      <= addr + step;
         lane      <= lane + LANE_IDX_W'(1);
         last_lane <= ((int'(lane) + 2) == int'(LANES));
      end
   end

endmodule

// File: rtl/vector_data_memory.sv
// Vector load/store controller: IO window decode, per-lane serialisation to main
// memory, sign-extended load return over a valid/ready response.
// Build option: define VMEM_STRIDE_EN to honour req_stride (otherwise stride is 1).
module vector_data_memory
   import vmem_pkg::*;
#(
   parameter  int unsigned LANES      = LANES_D,
   parameter  int unsigned LANE_W     = LANE_W_D,
   parameter  int unsigned STORE_W    = STORE_W_D,
   parameter  int unsigned ADDR_W     = ADDR_W_D,
   parameter  int unsigned MEM_ADDR_W = MEM_ADDR_W_D,
   parameter  int unsigned IO_SIZE    = IO_SIZE_D,
   parameter  int unsigned MEM_LAT    = MEM_LAT_D,
   localparam int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int unsigned DRAIN_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   vector_data_memory_if.slave    bus,
   output logic [MEM_ADDR_W-1:0]  mem_addr,
   output logic                   mem_we,
   output logic [STORE_W-1:0]     mem_wdata,
   input  logic [STORE_W-1:0]     mem_rdata,
   output logic                   io_en,
   output logic                   io_we,
   output logic [7:0]             io_addr,
   output logic [LANE_W-1:0]      io_wdata,
   input  logic [LANE_W-1:0]      io_rdata
);

   vmem_state_e               state_q;
   vmem_state_e               state_d;
   logic                      accept_c;
   logic                      is_io_c;
   logic                      gen_start;
   logic                      gen_adv;
   logic                      mem_we_d;
   logic                      mem_re_d;
   logic                      io_en_d;
   logic                      io_we_d;
   logic                      mem_re_q;
   logic [MEM_LAT-1:0]        rd_pipe;
   logic [DRAIN_W-1:0]        drain_q;
   logic                      write_q;
   logic [LANES*LANE_W-1:0]   wdata_q;
   logic [LANE_IDX_W-1:0]     cap_cnt;
   logic [LANE_IDX_W-1:0]     lane;
   logic                      last_lane;
   logic [MEM_ADDR_W-1:0]     step;
   logic [MEM_ADDR_W-1:0]     offset_c;

   assign accept_c = (state_q == IDLE) && bus.req_valid;
   assign is_io_c  = bus.req_addr < ADDR_W'(IO_SIZE);
   assign offset_c = MEM_ADDR_W'(bus.req_addr - ADDR_W'(IO_SIZE));

`ifdef VMEM_STRIDE_EN
   logic [MEM_ADDR_W-1:0] stride_q;

   // Stride captured at accept so later request changes are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stride_q <= '0;
      end else if (accept_c) begin
         stride_q <= bus.req_stride;
      end
   end

   assign step = stride_q;
`else
   assign step = MEM_ADDR_W'(1);
`endif

   vmem_addr_gen #(
      .LANES      (LANES),
      .MEM_ADDR_W (MEM_ADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .start      (gen_start),
      .advance    (gen_adv),
      .start_addr (offset_c),
      .step       (step),
      .addr       (mem_addr),
      .lane       (lane),
      .last_lane  (last_lane)
   );

   // Next-state and next-output decode.
   always_comb begin
      state_d   = state_q;
      gen_start = 1'b0;
      gen_adv   = 1'b0;
      mem_we_d  = 1'b0;
      mem_re_d  = 1'b0;
      io_en_d   = 1'b0;
      io_we_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (is_io_c) begin
                  state_d = IO;
                  io_en_d = 1'b1;
                  io_we_d = bus.req_write;
               end else begin
                  state_d   = ISSUE;
                  gen_start = 1'b1;
                  mem_we_d  = bus.req_write;
                  mem_re_d  = !bus.req_write;
               end
            end
         end
         IO: begin
            state_d = RESP;
         end
         ISSUE: begin
            if (last_lane) begin
               state_d = write_q ? RESP : DRAIN;
            end else begin
               gen_adv  = 1'b1;
               mem_we_d = write_q;
               mem_re_d = !write_q;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_W'(MEM_LAT - 1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and control-output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_re_q      <= 1'b0;
         io_en         <= 1'b0;
         io_we         <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus.req_ready <= (state_d == IDLE);
         bus.rsp_valid <= (state_d == RESP);
         mem_we        <= mem_we_d;
         mem_re_q      <= mem_re_d;
         io_en         <= io_en_d;
         io_we         <= io_we_d;
      end
   end

   // Counts the cycles spent waiting for the last load return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_q <= '0;
      end else if (state_q == DRAIN) begin
         drain_q <= drain_q + DRAIN_W'(1);
      end else begin
         drain_q <= '0;
      end
   end

   // Read-issue flags delayed to line up with mem_rdata.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= mem_re_q;
         for (int unsigned k = 1; k < MEM_LAT; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
         end
      end
   end

   // Request capture, per-lane store data, IO and load return assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_q       <= 1'b0;
         wdata_q       <= '0;
         io_addr       <= '0;
         io_wdata      <= '0;
         mem_wdata     <= '0;
         cap_cnt       <= '0;
         bus.rsp_rdata <= '0;
      end else if (accept_c) begin
         write_q       <= bus.req_write;
         wdata_q       <= bus.req_wdata;
         io_addr       <= bus.req_addr[7:0];
         io_wdata      <= bus.req_wdata[LANE_W-1:0];
         mem_wdata     <= bus.req_wdata[STORE_W-1:0];
         cap_cnt       <= '0;
         bus.rsp_rdata <= '0;
      end else begin
         if (gen_adv) begin
            mem_wdata <= wdata_q[(int'(lane) + 1) * int'(LANE_W) +: STORE_W];
         end
         if ((state_q == IO) && !write_q) begin
            bus.rsp_rdata <= {{((LANES - 1) * LANE_W){io_rdata[LANE_W-1]}}, io_rdata};
         end
         if (rd_pipe[MEM_LAT-1]) begin
            bus.rsp_rdata[int'(cap_cnt) * int'(LANE_W) +: LANE_W] <=
               LANE_W'(sign_extend(SEXT_W'(mem_rdata), STORE_W));
            cap_cnt <= cap_cnt + LANE_IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory with queued expected responses and writes.
module tb_vector_data_memory;

   localparam int unsigned LANES      = 6;
   localparam int unsigned LANE_W     = 24;
   localparam int unsigned STORE_W    = 12;
   localparam int unsigned ADDR_W     = 20;
   localparam int unsigned MEM_ADDR_W = 19;
   localparam int unsigned DW         = LANES * LANE_W;

   logic                  clk;
   logic                  rst;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic                  mem_we;
   logic [STORE_W-1:0]    mem_wdata;
   logic [STORE_W-1:0]    mem_rdata;
   logic                  io_en;
   logic                  io_we;
   logic [7:0]            io_addr;
   logic [LANE_W-1:0]     io_wdata;
   logic [LANE_W-1:0]     io_rdata;
   logic [LANE_W-1:0]     io_val;

   int tests;
   int fails;

   logic [DW-1:0] rsp_q [$];
   logic [30:0]   wr_q  [$];

   vector_data_memory_if #(
      .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W)
   ) bus ();

   vector_data_memory #(
      .LANES(LANES), .LANE_W(LANE_W), .STORE_W(STORE_W), .ADDR_W(ADDR_W),
      .MEM_ADDR_W(MEM_ADDR_W), .IO_SIZE(76), .MEM_LAT(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .io_en     (io_en),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IO register 5 returns io_val; every other index reads zero.
   assign io_rdata = (io_addr == 8'd5) ? io_val : '0;

   // Main memory model, one-cycle read latency; the six low address bits select an entry.
   bit [STORE_W-1:0] mem_arr [64];
   bit               mem_wr  [64];

   function automatic logic [STORE_W-1:0] init_val(input logic [5:0] a);
      case (a)
         6'd4:    return 12'h001;
         6'd7:    return 12'h7FF;
         6'd10:   return 12'h800;
         6'd13:   return 12'hABC;
         6'd19:   return 12'h5A5;
         default: return 12'h000;
      endcase
   endfunction

   always @(posedge clk) begin
      mem_rdata <= mem_wr[mem_addr[5:0]] ? mem_arr[mem_addr[5:0]] : init_val(mem_addr[5:0]);
      if (mem_we) begin
         mem_arr[mem_addr[5:0]] <= mem_wdata;
         mem_wr[mem_addr[5:0]]  <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Response scoreboard: compare on every completed handshake.
   always @(negedge clk) begin
      if (rst && bus.rsp_valid && bus.rsp_ready) begin
         if (rsp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got %h, expected no response", bus.rsp_rdata);
         end else begin
            chk("rsp_rdata", bus.rsp_rdata, rsp_q.pop_front());
         end
      end
      if (rst && mem_we) begin
         if (wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mem_wr_unexpected: got addr %h data %h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            logic [30:0] e;
            e = wr_q.pop_front();
            chk("mem_wr_addr", DW'(mem_addr), DW'(e[30:12]));
            chk("mem_wr_data", DW'(mem_wdata), DW'(e[11:0]));
         end
      end
   end

   task automatic push_w(input logic [MEM_ADDR_W-1:0] a, input logic [STORE_W-1:0] d);
      wr_q.push_back({a, d});
   endtask

   // Issue one request, check its latency, port activity and handshake.
   task automatic run_req(input string name, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [MEM_ADDR_W-1:0] stride, input logic [DW-1:0] wdata,
                          input bit is_io, input int exp_lat, input logic [DW-1:0] exp_rdata,
                          input bit chk_addrs, input logic [LANES*MEM_ADDR_W-1:0] exp_addrs,
                          input int hold);
      int n;
      bit got;
      @(negedge clk);
      bus.rsp_ready  = (hold == 0);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr   = addr;
      bus.req_stride = stride;
      bus.req_wdata  = wdata;
      rsp_q.push_back(exp_rdata);
      chk({name, "_req_ready_idle"}, DW'(bus.req_ready), DW'(1));
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_write  = ~wr;
      bus.req_addr   = '1;
      bus.req_stride = 19'h5;
      bus.req_wdata  = {LANES{24'hA5A5A5}};
      chk({name, "_req_ready_busy"}, DW'(bus.req_ready), DW'(0));
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         if (chk_addrs && n < int'(LANES)) begin
            chk($sformatf("%s_mem_addr%0d", name, n), DW'(mem_addr),
                DW'(exp_addrs[n*MEM_ADDR_W +: MEM_ADDR_W]));
         end
         if (is_io && n == 0) begin
            chk({name, "_io_en"}, DW'(io_en), DW'(1));
            chk({name, "_io_we"}, DW'(io_we), DW'(wr));
            chk({name, "_io_addr"}, DW'(io_addr), DW'(addr[7:0]));
            if (wr) chk({name, "_io_wdata"}, DW'(io_wdata), DW'(wdata[LANE_W-1:0]));
         end
         @(posedge clk);
         #1;
         n++;
         if (bus.rsp_valid) got = 1'b1;
      end
      chk({name, "_latency"}, DW'(n), DW'(exp_lat));
      if (is_io) chk({name, "_io_en_off"}, DW'(io_en), DW'(0));
      for (int h = 0; h < hold; h++) begin
         chk({name, "_hold_valid"}, DW'(bus.rsp_valid), DW'(1));
         chk({name, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
         chk({name, "_hold_req_ready"}, DW'(bus.req_ready), DW'(0));
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_rsp_done"}, DW'(bus.rsp_valid), DW'(0));
      chk({name, "_req_ready_back"}, DW'(bus.req_ready), DW'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LANES*MEM_ADDR_W-1:0] sa;
      logic [DW-1:0]               sd;
      tests          = 0;
      fails          = 0;
      io_val         = 24'h800001;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_stride = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      chk("rst_rsp_rdata", bus.rsp_rdata, DW'(0));
      chk("rst_mem_we", DW'(mem_we), DW'(0));
      chk("rst_mem_addr", DW'(mem_addr), DW'(0));
      chk("rst_mem_wdata", DW'(mem_wdata), DW'(0));
      chk("rst_io_en", DW'(io_en), DW'(0));
      chk("rst_io_we", DW'(io_we), DW'(0));
      @(negedge clk);
      rst = 1'b1;

      // Contiguous store at 100 -> lanes at 24..29, upper lane bits dropped.
      push_w(19'd24, 12'h123); push_w(19'd25, 12'h800); push_w(19'd26, 12'h000);
      push_w(19'd27, 12'h000); push_w(19'd28, 12'h000); push_w(19'd29, 12'hFFF);
      run_req("store100", 1'b1, 20'd100, 19'd1,
              {24'h000FFF, 24'h0, 24'h0, 24'h0, 24'h000800, 24'h000123},
              1'b0, 6, '0, 1'b1,
              {19'd29, 19'd28, 19'd27, 19'd26, 19'd25, 19'd24}, 0);

      // Load back with sign extension from bit 11.
      run_req("load100", 1'b0, 20'd100, 19'd1, '0, 1'b0, 7,
              {24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'hFFF800, 24'h000123}, 1'b1,
              {19'd29, 19'd28, 19'd27, 19'd26, 19'd25, 19'd24}, 0);

      // Strided load at 80 (offset 4), stride 3.
`ifdef VMEM_STRIDE_EN
      sa = {19'd19, 19'd16, 19'd13, 19'd10, 19'd7, 19'd4};
      sd = {24'h0005A5, 24'h000000, 24'hFFFABC, 24'hFFF800, 24'h0007FF, 24'h000001};
`else
      sa = {19'd9, 19'd8, 19'd7, 19'd6, 19'd5, 19'd4};
      sd = {24'h000000, 24'h000000, 24'h0007FF, 24'h000000, 24'h000000, 24'h000001};
`endif
      run_req("stride", 1'b0, 20'd80, 19'd3, '0, 1'b0, 7, sd, 1'b1, sa, 0);

      // IO load and store at register 5.
      run_req("io_load", 1'b0, 20'd5, 19'd0, '0, 1'b1, 1,
              {{5{24'hFFFFFF}}, 24'h800001}, 1'b0, '0, 0);
      run_req("io_store", 1'b1, 20'd5, 19'd0,
              {24'h0, 24'h0, 24'h0, 24'h0, 24'hABCDEF, 24'h000042},
              1'b1, 1, '0, 1'b0, '0, 0);

      // Response backpressure for three cycles.
      run_req("backpressure", 1'b0, 20'd100, 19'd1, '0, 1'b0, 7,
              {24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'hFFF800, 24'h000123}, 1'b0, '0, 3);

      // Address wrap past 2^19.
      push_w(19'h7FFFE, 12'h001); push_w(19'h7FFFF, 12'h002); push_w(19'd0, 12'h003);
      push_w(19'd1, 12'h004);     push_w(19'd2, 12'h005);     push_w(19'd3, 12'h006);
      run_req("wrap", 1'b1, 20'h8004A, 19'd1,
              {24'h000006, 24'h000005, 24'h000004, 24'h123003, 24'h000002, 24'hFFF001},
              1'b0, 6, '0, 1'b1,
              {19'd3, 19'd2, 19'd1, 19'd0, 19'h7FFFF, 19'h7FFFE}, 0);

      // Reset during lane 2 of a store: lanes 0 and 1 land, the rest never do.
      push_w(19'd24, 12'hAAA);
      push_w(19'd25, 12'hBBB);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 20'd100;
      bus.req_stride = 19'd1;
      bus.req_wdata = {24'h000FFF, 24'h000EEE, 24'h000DDD, 24'h000CCC, 24'h000BBB, 24'h000AAA};
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_lane2_we", DW'(mem_we), DW'(1));
      chk("abort_lane2_addr", DW'(mem_addr), DW'(26));
      rst = 1'b0;
      #1;
      chk("abort_mem_we", DW'(mem_we), DW'(0));
      chk("abort_mem_addr", DW'(mem_addr), DW'(0));
      chk("abort_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      chk("abort_req_ready", DW'(bus.req_ready), DW'(1));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("after_rst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("after_rst_mem_we", DW'(mem_we), DW'(0));

      run_req("load_after_abort", 1'b0, 20'd100, 19'd1, '0, 1'b0, 7,
              {24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'hFFFBBB, 24'hFFFAAA}, 1'b0, '0, 0);

      repeat (2) @(posedge clk);
      chk("rsp_queue_empty", DW'(rsp_q.size()), DW'(0));
      chk("wr_queue_empty", DW'(wr_q.size()), DW'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vector_data_memory.md
# vector_data_memory

Parametrised vector load/store controller between the core's memory stage and the data-side storage. Decodes each request into the memory-mapped IO region (scalar, low addresses) or main memory (rebased above the IO window). Serialises a LANES-wide vector into one narrow main-memory lane access per cycle, with optional strided addressing. Returns sign-extended read data over a valid/ready response handshake.

## Interface
- LANES, 6: vector lanes per request
- LANE_W, 24: core-side lane width
- STORE_W, 12: stored bits per lane, at most LANE_W
- ADDR_W, 20: request address width
- MEM_ADDR_W, 19: main-memory address width
- IO_SIZE, 76: IO window is addresses 0..IO_SIZE-1
- MEM_LAT, 1: main-memory read latency in cycles, at least 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  base address
- req_stride  in  MEM_ADDR_W  lane-to-lane address step
- req_wdata  in  LANES*LANE_W  store data; lane i is bits [i*LANE_W +: LANE_W]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  LANES*LANE_W  load data; zero for stores
- mem_addr  out  MEM_ADDR_W  main-memory address
- mem_we  out  1  main-memory write strobe
- mem_wdata  out  STORE_W  main-memory write data
- mem_rdata  in  STORE_W  main-memory read data, MEM_LAT cycles after its address
- io_en  out  1  IO access strobe
- io_we  out  1  IO write
- io_addr  out  8  IO register index, req_addr[7:0]
- io_wdata  out  LANE_W  lane 0 of req_wdata
- io_rdata  in  LANE_W  IO read data, combinational from io_addr

## Operation
- The FSM has five states: IDLE, IO, ISSUE, DRAIN, RESP. req_ready=1 only in IDLE. A request is accepted when req_valid and req_ready are both high.
- Region decode uses the base address only. If req_addr < IO_SIZE, the request goes to IO. Otherwise it goes to main memory at base offset (req_addr − IO_SIZE) mod 2^MEM_ADDR_W. All lanes stay in the region of the base address.
- Lane i address: (offset + i*stride) mod 2^MEM_ADDR_W. Wrap-around is silent.
- IO state lasts one cycle:
  - io_en=1 and io_we=req_write.
  - For a load, rsp_rdata lane 0 is io_rdata. Lanes 1..LANES-1 are filled with io_rdata[LANE_W-1].
  - Then go to RESP.
- ISSUE state lasts LANES cycles, one lane per cycle, lane 0 first.
  - A store drives mem_we=1 and mem_wdata = lane[STORE_W-1:0]. Upper bits are discarded.
  - A load drives mem_we=0 and captures each return into its lane slot, sign-extended from bit STORE_W-1.
- After ISSUE, a load enters DRAIN for MEM_LAT cycles, then RESP. A store goes directly to RESP.
- RESP holds rsp_valid=1 with stable rsp_rdata until rsp_ready=1, then returns to IDLE. No new request is accepted before the response is taken.
- The request fields (write, addr, stride, wdata) are registered at accept. Input changes after accept are ignored.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, io_en=0, io_we=0. Asserting reset mid-operation aborts the operation immediately (asynchronous). Lanes already written stay written.

## Timing
- Let E0 be the accept edge.
- IO: io_en is high in the cycle after E0. rsp_valid rises at E1.
- Main store: lane i is driven in cycle i after E0. rsp_valid rises at E(LANES).
- Main load: rsp_valid rises at E(LANES+MEM_LAT).
- Minimum request spacing: response latency + 1 cycle.
- mem_* and io_* outputs are registered or decoded from state only. There is no combinational path from req_* to the memory ports.

## Configuration
- VMEM_STRIDE_EN defined: req_stride is honoured.
- VMEM_STRIDE_EN undefined: stride is fixed at 1, req_stride is ignored, and the stride multiplier/adder is removed. Lane i address is offset + i.

## Structure
- Package vmem_pkg holds:
  - the state enum (IDLE, IO, ISSUE, DRAIN, RESP);
  - the default parameter constants;
  - a sign_extend function from STORE_W to LANE_W.
- Sub-module vmem_addr_gen: registered lane counter and running address (offset, +stride each cycle), with a last_lane flag.
- A return-capture counter, delayed MEM_LAT cycles from issue, indexes the lane written with mem_rdata.

## Test plan
(Default parameters unless stated, stride enabled.)
- Contiguous store at addr 100, lanes 0x000123, 0x000800, 0, 0, 0, 0x000FFF -> mem_addr 24..29 with mem_we=1 for 6 cycles, mem_wdata 0x123, 0x800, 0, 0, 0, 0xFFF; rsp_valid at E6.
- Load at addr 100 after that store -> rsp_rdata lanes 0x000123, 0xFFF800, 0, 0, 0, 0xFFFFFF; rsp_valid at E7.
- Strided load, addr 80, stride 3 -> mem_addr 4, 7, 10, 13, 16, 19.
- IO load, addr 5, io_rdata 0x800001 -> io_addr 5, io_en for one cycle, lane 0 = 0x800001, lanes 1-5 = 0xFFFFFF. Separately, IO store at addr 5 with lane 0 = 0x000042 -> io_we=1, io_wdata 0x000042.
- Backpressure: hold rsp_ready low for 3 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0; handshake completes on the cycle rsp_ready rises.
- Wrap, addr 0x8004A, stride 1 -> mem_addr 0x7FFFE, 0x7FFFF, 0, 1, 2, 3. Reset asserted during lane 2 -> mem_we=0 at once; req_ready=1 after reset release.
